// File: rtl/fpga_spi_cs_arbiter.sv
// ---------------------------------------------------------------------------
// fpga_spi_cs_arbiter
//
// Shares one SPI shift engine among NREQ chip-select clients (CLCD, ADC,
// shield 0/1). A round-robin arbiter picks an owner, then the sequencer
// drives that client's active-low chip select through SETUP / ACTIVE / HOLD /
// GAP phases with programmable lengths. It issues xfer_start pulses to the
// engine and consumes its xfer_done pulses. A locked owner keeps nCS low
// across back-to-back transfers. A watchdog aborts an ACTIVE phase that never
// completes.
//
// Ports
//   PCLK        in   clock
//   PRESET      in   synchronous active-high reset
//   req         in   [NREQ]  level request per client
//   lock        in   [NREQ]  keep ownership for the next transfer while req high
//   mask        in   [NREQ]  1 = client disabled (never granted)
//   xfer_done   in           one-cycle pulse from the SPI engine
//   gnt         out  [NREQ]  one-hot owner, asserted during ACTIVE only
//   cs_n        out  [NREQ]  active-low chip selects, at most one low
//   xfer_start  out          one-cycle pulse to the SPI engine
//   cur_id      out  [ID_W]  index of the current/last owner
//   busy        out          sequencer not idle
//   timeout     out          one-cycle pulse on watchdog expiry
//   stray_done  out          one-cycle pulse: xfer_done outside a valid window
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module fpga_spi_cs_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int CS_SETUP = 2,
  parameter  int CS_HOLD  = 2,
  parameter  int CS_GAP   = 1,
  parameter  int TIMEOUT  = 1024,
  localparam int ID_W     = $clog2(NREQ)
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  logic [NREQ-1:0] mask,
  input  logic            xfer_done,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] cs_n,
  output logic            xfer_start,
  output logic [ID_W-1:0] cur_id,
  output logic            busy,
  output logic            timeout,
  output logic            stray_done
);

  // Watchdog counter only needs to reach TIMEOUT-1; keep at least one bit so
  // the declaration stays legal when the watchdog is disabled.
  localparam int WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  // Phase counters are loaded with length-1 and count down to zero.
  localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Registered state
  state_t          state;
  logic [7:0]      phase_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [ID_W-1:0] rr_ptr;

  // Next-state values
  state_t          state_d;
  logic [7:0]      phase_d;
  logic [WD_W-1:0] wd_d;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] owner_d;
  logic            start_d;
  logic            timeout_d;
  logic            stray_d;

  // Registered-output next values
  logic [NREQ-1:0] cs_n_d;
  logic [NREQ-1:0] gnt_d;
  logic            busy_d;

  // Arbitration
  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;

  // Transfer-window qualifiers
  logic done_ok;
  logic keep_owner;
  logic wd_expired;

  assign eligible = req & ~mask;

  // Round-robin search starting one past the last winner, wrapping at NREQ
  // (NREQ need not be a power of two, so wrap explicitly).
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // A done is only meaningful in ACTIVE after the start pulse cycle; the
  // engine cannot finish in the same cycle it was told to begin.
  assign done_ok    = xfer_done && (state == ST_ACTIVE) && !xfer_start;
  assign keep_owner = lock[cur_id] && req[cur_id] && !mask[cur_id];
  assign wd_expired = (TIMEOUT != 0) && (state == ST_ACTIVE) &&
                      (wd_cnt == WD_W'(TIMEOUT - 1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    phase_d   = phase_cnt;
    wd_d      = wd_cnt;
    ptr_d     = rr_ptr;
    owner_d   = cur_id;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    stray_d   = xfer_done && !done_ok;

    unique case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_SETUP;
          phase_d = SETUP_LOAD;
          owner_d = win_id;
          ptr_d   = win_id;
        end
      end

      ST_SETUP: begin
        if (phase_cnt == 8'd0) begin
          state_d = ST_ACTIVE;
          start_d = 1'b1;
        end else begin
          phase_d = phase_cnt - 8'd1;
        end
      end

      ST_ACTIVE: begin
        wd_d = wd_cnt + 1'b1;
        // A done arriving on the expiry cycle still counts as completion.
        if (done_ok) begin
          if (keep_owner) begin
            start_d = 1'b1;
          end else begin
            state_d = ST_HOLD;
            phase_d = HOLD_LOAD;
          end
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
          phase_d   = HOLD_LOAD;
        end
      end

      ST_HOLD: begin
        if (phase_cnt == 8'd0) begin
          state_d = ST_GAP;
          phase_d = GAP_LOAD;
        end else begin
          phase_d = phase_cnt - 8'd1;
        end
      end

      ST_GAP: begin
        if (phase_cnt == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_cnt - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Watchdog restarts with every start pulse, including locked repeats.
    if (start_d) begin
      wd_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: computed from the next state so the outputs can be
  // registered and still line up with the state they describe.
  // -------------------------------------------------------------------------
  always_comb begin
    cs_n_d = '1;
    gnt_d  = '0;
    busy_d = (state_d != ST_IDLE);
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == owner_d) begin
        cs_n_d[i] = !((state_d == ST_SETUP) || (state_d == ST_ACTIVE) ||
                      (state_d == ST_HOLD));
        gnt_d[i]  = (state_d == ST_ACTIVE);
      end
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      wd_cnt     <= '0;
      // Pointer parked on the last client so client 0 wins the first search.
      rr_ptr     <= ID_W'(NREQ - 1);
      cur_id     <= '0;
      cs_n       <= '1;
      gnt        <= '0;
      xfer_start <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      stray_done <= 1'b0;
    end else begin
      state      <= state_d;
      phase_cnt  <= phase_d;
      wd_cnt     <= wd_d;
      rr_ptr     <= ptr_d;
      cur_id     <= owner_d;
      cs_n       <= cs_n_d;
      gnt        <= gnt_d;
      xfer_start <= start_d;
      busy       <= busy_d;
      timeout    <= timeout_d;
      stray_done <= stray_d;
    end
  end

endmodule
